// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the data port has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_done,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wmask,
  output logic                  d_done,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wmask,
  input  logic                  m_ack,
  input  logic [DATA_W-1:0]     m_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t               state, state_n;
  logic [ADDR_W-1:0]    lat_addr;
  logic [DATA_W-1:0]    lat_wdata;
  logic [DATA_W/8-1:0]  lat_wmask;
  logic                 lat_we;
  logic                 lat_port;   // 1 = data port owns the transaction
  logic [7:0]           cnt;
  logic                 grant_d;
  logic                 start;
  logic                 finish;
  logic                 timed_out;
`ifdef ARB_ROUND_ROBIN_EN
  logic                 last_grant; // 1 = data port was granted last
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    grant_d   = d_req & (~i_req | ~last_grant);
`else
    grant_d   = d_req;
`endif
    case (state)
      IDLE: begin
        if (i_req | d_req) begin
          start   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        // An ack on the final allowed cycle takes precedence over the timeout.
        if (m_ack) begin
          finish  = 1'b1;
          state_n = DONE;
        end else if (cnt == TMO_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_n   = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      lat_we    <= 1'b0;
      lat_port  <= 1'b0;
      cnt       <= '0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      if (start) begin
        lat_port  <= grant_d;
        lat_addr  <= grant_d ? d_addr : i_addr;
        lat_we    <= grant_d & d_we;
        lat_wdata <= grant_d ? d_wdata : '0;
        lat_wmask <= grant_d ? d_wmask : '0;
        cnt       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant <= grant_d;
`endif
      end
      if ((state == ISSUE) && !finish) cnt <= cnt + 8'd1;
      if (finish) begin
        if (lat_port) begin
          d_rdata <= timed_out ? '0 : m_rdata;
          d_err   <= timed_out;
        end else begin
          i_rdata <= timed_out ? '0 : m_rdata;
          i_err   <= timed_out;
        end
      end
    end
  end

  assign m_req   = (state == ISSUE);
  assign m_we    = lat_we;
  assign m_addr  = lat_addr;
  assign m_wdata = lat_wdata;
  assign m_wmask = lat_wmask;
  assign i_done  = (state == DONE) & ~lat_port;
  assign d_done  = (state == DONE) &  lat_port;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int TMO = 15;

  logic        clk, rst;
  logic        i_req, i_done, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_done, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wmask;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wmask;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one outstanding transaction, tracked by phase flags.
  bit          mdl_bus, mdl_rep, mdl_port, mdl_last_d;
  logic [31:0] mdl_addr, mdl_wdata, mdl_irdata, mdl_drdata;
  logic        mdl_we, mdl_ierr, mdl_derr;
  logic [3:0]  mdl_wmask;
  int          mdl_wait;

  task automatic model_reset();
    mdl_bus = 0; mdl_rep = 0; mdl_port = 0; mdl_last_d = 0;
    mdl_addr = '0; mdl_wdata = '0; mdl_we = 1'b0; mdl_wmask = '0; mdl_wait = 0;
    mdl_irdata = '0; mdl_drdata = '0; mdl_ierr = 1'b0; mdl_derr = 1'b0;
  endtask

  task automatic model_report(input logic [31:0] rd, input logic err);
    if (mdl_port) begin mdl_drdata = rd; mdl_derr = err; end
    else          begin mdl_irdata = rd; mdl_ierr = err; end
    mdl_bus = 0;
    mdl_rep = 1;
  endtask

  task automatic model_step();
    bit pick_d;
    if (mdl_rep) begin
      mdl_rep = 0;
    end else if (mdl_bus) begin
      if (m_ack) model_report(m_rdata, 1'b0);
      else begin
        mdl_wait++;
        if (mdl_wait == TMO) model_report(32'h0, 1'b1);
      end
    end else if (i_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_d = (i_req && d_req) ? !mdl_last_d : d_req;
`else
      pick_d = d_req;
`endif
      mdl_port   = pick_d;
      mdl_last_d = pick_d;
      mdl_addr   = pick_d ? d_addr : i_addr;
      mdl_we     = pick_d ? d_we : 1'b0;
      mdl_wdata  = pick_d ? d_wdata : 32'h0;
      mdl_wmask  = pick_d ? d_wmask : 4'h0;
      mdl_bus    = 1;
      mdl_wait   = 0;
    end
  endtask

  // Compare on the falling edge; inputs only change just after rising edges.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      check("cyc_m_req", 64'(m_req), 64'(mdl_bus));
      if (mdl_bus || rst) begin
        check("cyc_m_we",    64'(m_we),    64'(mdl_we));
        check("cyc_m_addr",  64'(m_addr),  64'(mdl_addr));
        check("cyc_m_wdata", 64'(m_wdata), 64'(mdl_wdata));
        check("cyc_m_wmask", 64'(m_wmask), 64'(mdl_wmask));
      end
      check("cyc_i_done",  64'(i_done),  64'(mdl_rep && !mdl_port));
      check("cyc_d_done",  64'(d_done),  64'(mdl_rep && mdl_port));
      check("cyc_i_rdata", 64'(i_rdata), 64'(mdl_irdata));
      check("cyc_i_err",   64'(i_err),   64'(mdl_ierr));
      check("cyc_d_rdata", 64'(d_rdata), 64'(mdl_drdata));
      check("cyc_d_err",   64'(d_err),   64'(mdl_derr));
      if (!rst) model_step();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_order;
    bit ok, got_d;
    int n;

    rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_wmask = '0; m_ack = 0; m_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_req",   64'(m_req),   64'h0);
    check("rst_i_done",  64'(i_done),  64'h0);
    check("rst_d_done",  64'(d_done),  64'h0);
    check("rst_i_rdata", 64'(i_rdata), 64'h0);
    check("rst_m_addr",  64'(m_addr),  64'h0);

    // Single instruction read, ack on second ISSUE cycle
    rst = 1'b0; i_req = 1; i_addr = 32'h100;
    tick();
    check("rd_m_req",  64'(m_req),  64'h1);
    check("rd_m_we",   64'(m_we),   64'h0);
    check("rd_m_addr", 64'(m_addr), 64'h100);
    tick();
    m_ack = 1; m_rdata = 32'hDEADBEEF;
    tick();
    m_ack = 0; m_rdata = '0;
    check("rd_i_done",  64'(i_done),  64'h1);
    check("rd_i_rdata", 64'(i_rdata), 64'hDEADBEEF);
    check("rd_i_err",   64'(i_err),   64'h0);
    check("rd_d_done",  64'(d_done),  64'h0);
    i_req = 0;
    tick();
    check("rd_i_done_pulse", 64'(i_done),  64'h0);
    check("rd_i_rdata_hold", 64'(i_rdata), 64'hDEADBEEF);
    check("rd_m_req_idle",   64'(m_req),   64'h0);

    // Data write
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678; d_wmask = 4'hF;
    tick();
    check("wr_m_req",   64'(m_req),   64'h1);
    check("wr_m_we",    64'(m_we),    64'h1);
    check("wr_m_addr",  64'(m_addr),  64'h40);
    check("wr_m_wdata", 64'(m_wdata), 64'h12345678);
    check("wr_m_wmask", 64'(m_wmask), 64'hF);
    tick();
    check("wr_m_wdata_hold", 64'(m_wdata), 64'h12345678);
    m_ack = 1; m_rdata = 32'h0BAD0BAD;
    tick();
    m_ack = 0;
    check("wr_d_done", 64'(d_done), 64'h1);
    check("wr_d_err",  64'(d_err),  64'h0);
    check("wr_i_done", 64'(i_done), 64'h0);
    d_req = 0; d_we = 0; d_wdata = '0; d_wmask = '0;
    tick();
    check("wr_d_done_pulse", 64'(d_done), 64'h0);

    // Tie between ports, four back-to-back transactions after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 4'b0101;
`else
    exp_order = 4'b1111;
`endif
    i_req = 1; d_req = 1; i_addr = 32'h200; d_addr = 32'h300;
    m_ack = 1; m_rdata = 32'h5A5A0001;
    for (int t = 0; t < 4; t++) begin
      ok = 0;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (m_req) begin ok = 1; break; end
      end
      check("tie_grant_seen", 64'(ok), 64'h1);
      got_d = (m_addr == 32'h300);
      check("tie_order", 64'(got_d), 64'(exp_order[t]));
      tick();
      check("tie_done", 64'(got_d ? d_done : i_done), 64'h1);
      m_rdata = m_rdata + 32'h1;
      if (t == 3) begin i_req = 0; d_req = 0; m_ack = 0; end
    end
    tick();

    // Timeout with no ack
    d_req = 1; d_addr = 32'h80;
    tick();
    n = 0;
    while (m_req && n < 40) begin
      n++;
      tick();
    end
    check("tmo_m_req_cycles", 64'(n), 64'd15);
    check("tmo_d_done",  64'(d_done),  64'h1);
    check("tmo_d_err",   64'(d_err),   64'h1);
    check("tmo_d_rdata", 64'(d_rdata), 64'h0);
    d_req = 0;
    tick();
    check("tmo_d_err_hold", 64'(d_err), 64'h1);

    // Ack on the 15th ISSUE cycle beats the timeout
    d_req = 1;
    tick();
    repeat (14) tick();
    check("ack15_m_req", 64'(m_req), 64'h1);
    m_ack = 1; m_rdata = 32'hCAFEF00D;
    tick();
    m_ack = 0;
    check("ack15_d_done",  64'(d_done),  64'h1);
    check("ack15_d_err",   64'(d_err),   64'h0);
    check("ack15_d_rdata", 64'(d_rdata), 64'hCAFEF00D);
    d_req = 0;
    tick();

    // Reset in the middle of ISSUE, then a stray ack
    i_req = 1; i_addr = 32'h500;
    tick();
    tick();
    check("rstmid_m_req_before", 64'(m_req), 64'h1);
    rst = 1'b1;
    #1;
    check("rstmid_m_req",   64'(m_req),   64'h0);
    check("rstmid_i_done",  64'(i_done),  64'h0);
    check("rstmid_d_rdata", 64'(d_rdata), 64'h0);
    tick();
    rst = 1'b0; i_req = 0; m_ack = 1; m_rdata = 32'h77777777;
    tick();
    check("late_ack_i_done", 64'(i_done), 64'h0);
    check("late_ack_d_done", 64'(d_done), 64'h0);
    check("late_ack_m_req",  64'(m_req),  64'h0);
    tick();
    check("late_ack_i_done2", 64'(i_done), 64'h0);
    check("late_ack_i_rdata", 64'(i_rdata), 64'h0);
    m_ack = 0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; mask width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum ISSUE cycles without m_ack; range 1..255.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports i_req in 1, i_addr in ADDR_W: instruction-fetch read request and address.
REQ-007 SHALL have ports i_done out 1, i_rdata out DATA_W, i_err out 1: instruction completion pulse, read data and timeout flag.
REQ-008 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W, d_wmask in DATA_W/8: data-port request.
REQ-009 SHALL have ports d_done out 1, d_rdata out DATA_W, d_err out 1: data-port completion.
REQ-010 SHALL have ports m_req out 1, m_we out 1, m_addr out ADDR_W, m_wdata out DATA_W, m_wmask out DATA_W/8: shared memory request.
REQ-011 SHALL have ports m_ack in 1, m_rdata in DATA_W: memory completion; m_rdata is valid in the m_ack cycle.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> DONE -> IDLE, one transaction in flight.
REQ-013 IDLE: if any x_req=1, SHALL select a winner, latch its addr/we/wdata/wmask into internal registers, and enter ISSUE next cycle; instruction port latches we=0 and wmask=0.
REQ-014 ISSUE: SHALL drive m_req=1 and m_* from the latched registers, held stable until m_ack.
REQ-015 ISSUE with m_ack=1: SHALL capture m_rdata, clear error and enter DONE.
REQ-016 ISSUE: SHALL increment a cycle counter each cycle without m_ack; at the TIMEOUT-th cycle without m_ack, SHALL set error, capture rdata=0 and enter DONE.
REQ-017 m_ack in the same cycle as the counter reaching TIMEOUT: ack SHALL win, with err=0.
REQ-018 DONE: SHALL assert the winner's x_done=1 for exactly one cycle, with x_rdata and x_err from the captured values; then enter IDLE.
REQ-019 m_req SHALL be 0 in IDLE and DONE; m_ack outside ISSUE SHALL be ignored.
REQ-020 Requester SHALL hold x_req and its fields stable from assertion to x_done; x_req still high in the IDLE cycle after DONE SHALL start a new transaction.
REQ-021 Latency SHALL be: request in IDLE cycle N, m_req from N+1, done in the cycle after m_ack; minimum 3 cycles request-to-done.
REQ-022 x_rdata and x_err SHALL hold their last value when x_done=0; the non-winning port's done SHALL stay 0.
REQ-023 Changes on x_req during ISSUE or DONE SHALL NOT affect the current transaction.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, clear the counter and clear all latched fields.
REQ-025 During and after reset, all outputs SHALL be 0, and last_grant SHALL be instruction.
REQ-026 Reset mid-transaction SHALL abort the transaction with no done pulse; a late m_ack SHALL be ignored.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-028 Without ARB_ROUND_ROBIN_EN, the data port SHALL win whenever d_req=1.
REQ-029 With ARB_ROUND_ROBIN_EN, on a tie the port not granted last SHALL win; last_grant SHALL update on every grant; single requests SHALL always win.

Verification
REQ-030 Single read: i_req=1, i_addr=0x100, m_ack 2 cycles into ISSUE with m_rdata=0xDEADBEEF -> i_done pulse 1 cycle with i_rdata=0xDEADBEEF, i_err=0, m_we=0.
REQ-031 Write: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678, d_wmask=0xF -> m_* carry those values until m_ack, then d_done=1 for 1 cycle.
REQ-032 Tie: both requests held for 4 transactions with immediate m_ack -> without macro the order is D,D,D,D; with macro D,I,D,I.
REQ-033 Timeout: TIMEOUT=15, m_ack never asserted -> m_req high exactly 15 cycles, then d_done=1, d_err=1, d_rdata=0; with m_ack on cycle 15 -> d_err=0.
REQ-034 Reset: rst pulsed mid-ISSUE, then m_ack=1 -> m_req=0 at once, no done pulse, FSM in IDLE.
